contador_param: RTL and testbench
=================================

Name: contador_param

Overview:
- Parametrised successor to the team's 8-bit free-running counter: configurable width, four count modes (up 1, down 1, up 3, parallel load), count enable, wrap or saturate policy, registered terminal-count pulse and wrap-event counter.
- Used as the reusable counter primitive in the verification-course designs.
- The existing bench style applies unchanged: clock toggled directly, outputs sampled between edges.

Parameters:
- WIDTH, 8, width of count value q and load data d.
- SATURATE, 0, 0 = modular wrap; 1 = clamp at 0 / 2^WIDTH-1.
- EVT_W, 4, width of wrap-event counter evt_cnt.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- en  in  1  count enable; 0 holds all state.
- mode  in  2  00 up by 1, 01 down by 1, 10 up by 3, 11 load d.
- d  in  WIDTH  parallel load value (used only when mode=11).
- q  out  WIDTH  registered count value.
- rco  out  1  registered terminal-count pulse: overflow/underflow/clamp occurred on the last edge.
- evt_cnt  out  EVT_W  number of rco events since reset, saturating.

Behaviour:
- Reset: when reset=0 at a rising edge, q=0, rco=0, evt_cnt=0 after that edge, regardless of en, mode or d.
  - Reset has top priority.
  - No asynchronous effect: before the first sampling edge, outputs stay X.
  - Reset mid-count clears state on that edge.
  - Counting resumes on the first edge with reset=1.
- Hold: reset=1, en=0: q, evt_cnt hold; rco=0 (pulse never stretches).
- Count (reset=1, en=1), single-cycle latency: the new q is visible after the same edge.
  - Mode 00: next = q+1.
  - Mode 01: next = q-1.
  - Mode 10: next = q+3.
  - Arithmetic is done at WIDTH+1 bits to detect carry/borrow.
  - Event condition: the true result is > 2^WIDTH-1 (up modes) or < 0 (down mode).
- SATURATE=0:
  - q = result mod 2^WIDTH (e.g. WIDTH=8: 254+3 -> 1; 0-1 -> 255).
  - rco=1 on an event edge, else 0.
- SATURATE=1:
  - Up modes clamp to 2^WIDTH-1; down mode clamps to 0.
  - rco=1 on any edge where a clamp was applied, including when q was already at the limit (255 up by 1 -> stays 255, rco=1).
- Load (mode=11, en=1): q=d, rco=0, evt_cnt unchanged. Load ignores SATURATE.
- evt_cnt increments by 1 on every edge where rco is set to 1; it holds at 2^EVT_W-1 and never wraps.
- Mode changes take effect on the next edge with no pipeline: consecutive edges may use different modes. Each edge is evaluated purely from the current q and the current inputs.
- X/unknown on mode or en while reset=1 is a stimulus error and need not be handled.
- Purely synchronous logic, no latches, no gated clocks.

Test Plan:
- Reset then up count (WIDTH=8, SATURATE=0):
  - Stimulus: reset=0 for 2 edges, then reset=1, en=1, mode=00 for 256 edges.
  - Response: q reads 0 after reset, then 1,2,...,255,0. rco=1 only after the 256th counting edge (255->0). evt_cnt=1.
- Down wrap and up-by-3 wrap:
  - Stimulus: load d=2, then mode=01 for 3 edges, then load d=254, then mode=10 for 1 edge.
  - Response: q 1,0,255 with rco=1 only on the 255 step. Then q=1 with rco=1. evt_cnt=2.
- Saturate build (SATURATE=1):
  - Stimulus: load 253, mode=10 for 2 edges, then load 1, mode=01 for 3 edges.
  - Response: q 255 (rco=1), 255 (rco=1), then q 0 (rco=0), 0 (rco=1), 0 (rco=1). evt_cnt=4.
- Enable and load priority:
  - Stimulus: en=0 with mode=11, d=0xAA for 3 edges, then en=1 for 1 edge.
  - Response: q unchanged through the en=0 edges and rco=0. Then q=0xAA, evt_cnt unchanged.
- Mid-operation reset and evt_cnt saturation (EVT_W=2):
  - Stimulus: force 5 wraps using load 255 / up1 pairs, then assert reset=0 for one edge while en=1, mode=00.
  - Response: evt_cnt reads 3 after the 3rd, 4th and 5th wraps. After the reset edge, q=0, rco=0, evt_cnt=0. Next enabled edge gives q=1.

Source files
------------

// File: rtl/contador_param.sv
// Parametrised counter: up 1 / down 1 / up 3 / load, wrap or saturate,
// registered terminal-count pulse and a saturating count of those pulses.
module contador_param #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0,
   parameter int EVT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             rco,
   output logic [EVT_W-1:0] evt_cnt
);

   localparam logic [WIDTH:0]   ONE_EXT   = (WIDTH+1)'(1);
   localparam logic [WIDTH:0]   THREE_EXT = (WIDTH+1)'(3);
   localparam logic [WIDTH-1:0] Q_MAX     = '1;
   localparam logic [EVT_W-1:0] EVT_MAX   = '1;
   localparam logic [EVT_W-1:0] EVT_ONE   = EVT_W'(1);

   logic [WIDTH:0]   res_ext;
   logic             evt_hit;
   logic [WIDTH-1:0] q_next;

   // The extra top bit of res_ext is the carry (up) or borrow (down).
   always_comb begin
      res_ext = {1'b0, q};
      evt_hit = 1'b0;
      case (mode)
         2'b00: begin
            res_ext = {1'b0, q} + ONE_EXT;
            evt_hit = res_ext[WIDTH];
         end
         2'b01: begin
            res_ext = {1'b0, q} - ONE_EXT;
            evt_hit = res_ext[WIDTH];
         end
         2'b10: begin
            res_ext = {1'b0, q} + THREE_EXT;
            evt_hit = res_ext[WIDTH];
         end
         default: begin
            res_ext = {1'b0, d};
            evt_hit = 1'b0;
         end
      endcase

      q_next = res_ext[WIDTH-1:0];
      if (SATURATE && evt_hit) begin
         q_next = (mode == 2'b01) ? '0 : Q_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q       <= '0;
         rco     <= 1'b0;
         evt_cnt <= '0;
      end else if (!en) begin
         rco <= 1'b0;
      end else begin
         q   <= q_next;
         rco <= evt_hit;
         if (evt_hit && (evt_cnt != EVT_MAX)) begin
            evt_cnt <= evt_cnt + EVT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: three instances cover wrap mode,
// saturate mode and a narrow event counter.
module tb_contador_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance a: WIDTH=8, SATURATE=0, EVT_W=4
   logic       rst_a, en_a;
   logic [1:0] mode_a;
   logic [7:0] d_a, q_a;
   logic       rco_a;
   logic [3:0] evt_a;
   // instance b: WIDTH=8, SATURATE=1, EVT_W=4
   logic       rst_b, en_b;
   logic [1:0] mode_b;
   logic [7:0] d_b, q_b;
   logic       rco_b;
   logic [3:0] evt_b;
   // instance c: WIDTH=8, SATURATE=0, EVT_W=2
   logic       rst_c, en_c;
   logic [1:0] mode_c;
   logic [7:0] d_c, q_c;
   logic       rco_c;
   logic [1:0] evt_c;

   contador_param #(.WIDTH(8), .SATURATE(1'b0), .EVT_W(4)) dut_a (
      .clk(clk), .reset(rst_a), .en(en_a), .mode(mode_a), .d(d_a),
      .q(q_a), .rco(rco_a), .evt_cnt(evt_a));
   contador_param #(.WIDTH(8), .SATURATE(1'b1), .EVT_W(4)) dut_b (
      .clk(clk), .reset(rst_b), .en(en_b), .mode(mode_b), .d(d_b),
      .q(q_b), .rco(rco_b), .evt_cnt(evt_b));
   contador_param #(.WIDTH(8), .SATURATE(1'b0), .EVT_W(2)) dut_c (
      .clk(clk), .reset(rst_c), .en(en_c), .mode(mode_c), .d(d_c),
      .q(q_c), .rco(rco_c), .evt_cnt(evt_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle before sampling.
   task automatic tick(input string lbl);
      @(posedge clk);
      #1;
      $display("%-10s a: q=%0d rco=%0b evt=%0d | b: q=%0d rco=%0b evt=%0d | c: q=%0d rco=%0b evt=%0d",
               lbl, q_a, rco_a, evt_a, q_b, rco_b, evt_b, q_c, rco_c, evt_c);
   endtask

   initial begin
      rst_a = 1'b0; en_a = 1'b0; mode_a = 2'b00; d_a = 8'h00;
      rst_b = 1'b0; en_b = 1'b0; mode_b = 2'b00; d_b = 8'h00;
      rst_c = 1'b0; en_c = 1'b0; mode_c = 2'b00; d_c = 8'h00;

      // Reset for two edges
      tick("reset");
      tick("reset");
      chk("rst_q_a", q_a, 0);   chk("rst_rco_a", rco_a, 0);   chk("rst_evt_a", evt_a, 0);
      chk("rst_q_b", q_b, 0);   chk("rst_evt_b", evt_b, 0);
      chk("rst_q_c", q_c, 0);   chk("rst_evt_c", evt_c, 0);

      // Up count 256 edges, wraps once
      rst_a = 1'b1; en_a = 1'b1; mode_a = 2'b00;
      for (int i = 1; i <= 256; i++) begin
         tick("up1");
         chk("up_q", q_a, i % 256);
         chk("up_rco", rco_a, (i == 256) ? 1 : 0);
      end
      chk("up_evt", evt_a, 1);

      // Fresh reset, then down wrap and up-by-3 wrap
      rst_a = 1'b0;
      tick("reset");
      chk("rst2_evt", evt_a, 0);
      rst_a = 1'b1; mode_a = 2'b11; d_a = 8'd2;
      tick("load2");
      chk("ld2_q", q_a, 2);  chk("ld2_rco", rco_a, 0);
      mode_a = 2'b01;
      tick("dn1"); chk("dn_q1", q_a, 1);   chk("dn_rco1", rco_a, 0);
      tick("dn1"); chk("dn_q0", q_a, 0);   chk("dn_rco0", rco_a, 0);
      tick("dn1"); chk("dn_q255", q_a, 255); chk("dn_rco255", rco_a, 1);
      mode_a = 2'b11; d_a = 8'd254;
      tick("load254");
      chk("ld254_q", q_a, 254); chk("ld254_rco", rco_a, 0); chk("ld254_evt", evt_a, 1);
      mode_a = 2'b10;
      tick("up3");
      chk("up3_q", q_a, 1); chk("up3_rco", rco_a, 1); chk("up3_evt", evt_a, 2);

      // Enable off with a pending load: everything holds, rco drops
      en_a = 1'b0; mode_a = 2'b11; d_a = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         tick("hold");
         chk("hold_q", q_a, 1); chk("hold_rco", rco_a, 0); chk("hold_evt", evt_a, 2);
      end
      en_a = 1'b1;
      tick("loadAA");
      chk("ldAA_q", q_a, 8'hAA); chk("ldAA_rco", rco_a, 0); chk("ldAA_evt", evt_a, 2);

      // Saturating instance
      rst_b = 1'b1; en_b = 1'b1; mode_b = 2'b11; d_b = 8'd253;
      tick("load253");
      chk("s_ld_q", q_b, 253);
      mode_b = 2'b10;
      tick("s_up3"); chk("s_up3a_q", q_b, 255); chk("s_up3a_rco", rco_b, 1);
      tick("s_up3"); chk("s_up3b_q", q_b, 255); chk("s_up3b_rco", rco_b, 1);
      mode_b = 2'b00;
      tick("s_up1"); chk("s_up1_q", q_b, 255); chk("s_up1_rco", rco_b, 1);
      mode_b = 2'b11; d_b = 8'd1;
      tick("s_load1"); chk("s_ld1_q", q_b, 1); chk("s_ld1_rco", rco_b, 0);
      mode_b = 2'b01;
      tick("s_dn1"); chk("s_dna_q", q_b, 0); chk("s_dna_rco", rco_b, 0);
      tick("s_dn1"); chk("s_dnb_q", q_b, 0); chk("s_dnb_rco", rco_b, 1);
      tick("s_dn1"); chk("s_dnc_q", q_b, 0); chk("s_dnc_rco", rco_b, 1);
      chk("s_evt", evt_b, 5);

      // Narrow event counter saturates at 3
      rst_c = 1'b1; en_c = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         mode_c = 2'b11; d_c = 8'd255;
         tick("c_load");
         chk("c_ld_q", q_c, 255);
         mode_c = 2'b00;
         tick("c_wrap");
         chk("c_wrap_q", q_c, 0); chk("c_wrap_rco", rco_c, 1);
         chk("c_evt", evt_c, (k > 3) ? 3 : k);
      end
      // Reset mid-operation while enabled, then resume
      rst_c = 1'b0; mode_c = 2'b00;
      tick("c_reset");
      chk("c_rst_q", q_c, 0); chk("c_rst_rco", rco_c, 0); chk("c_rst_evt", evt_c, 0);
      rst_c = 1'b1;
      tick("c_up1");
      chk("c_resume_q", q_c, 1); chk("c_resume_rco", rco_c, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
